sm_acc_lanes: RTL

//  Parametrised multi-lane sign-magnitude accumulator for LeNet conv/FC partial sums.

---
 rtl/sm_acc_lanes.sv | 126 ++++++++++++
 1 files changed

// File: rtl/sm_acc_lanes.sv
// Multi-lane sign-magnitude accumulator: sums per-lane terms until in_last or MAX_TERMS beats,
// then presents one sign-magnitude result per lane. Define SM_ACC_SAT_EN to clamp overflowed lanes.
module sm_acc_lanes #(
    parameter int W         = 16,
    parameter int LANES     = 4,
    parameter int MAX_TERMS = 25
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANES*W-1:0] in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] out_data,
    output logic [LANES-1:0]   out_ovf
);

    // Wide enough that MAX_TERMS full-scale terms of either sign can never wrap.
    localparam int ACC_W = W + $clog2(MAX_TERMS) + 1;
    localparam int CNT_W = $clog2(MAX_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_TERMS - 1);

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        term_cnt;
    logic signed [ACC_W-1:0] acc [LANES];
    logic signed [ACC_W-1:0] sum [LANES];
    logic [LANES*W-1:0]      res_data;
    logic [LANES-1:0]        res_ovf;
    logic                    accept;
    logic                    close;

    // A beat offered alongside clear is dropped, so clear gates acceptance.
    assign accept = in_valid & in_ready & ~clear;
    assign close  = in_last | (term_cnt == LAST_CNT);

    // Negating a zero magnitude yields zero, so negative zero folds to +0 for free.
    function automatic logic signed [ACC_W-1:0] to_twos(input logic [W-1:0] sm);
        logic signed [ACC_W-1:0] mag;
        mag = signed'({{(ACC_W-W+1){1'b0}}, sm[W-2:0]});
        return sm[W-1] ? -mag : mag;
    endfunction

    // Returns {ovf, sign, mag}; the sign is suppressed whenever the emitted magnitude is zero.
    function automatic logic [W:0] to_sm(input logic signed [ACC_W-1:0] v);
        logic [ACC_W-1:0] mag_full;
        logic             ovf;
        logic [W-2:0]     mag;
        mag_full = v[ACC_W-1] ? $unsigned(-v) : $unsigned(v);
        ovf      = |mag_full[ACC_W-1:W-1];
`ifdef SM_ACC_SAT_EN
        mag      = ovf ? '1 : mag_full[W-2:0];
`else
        mag      = mag_full[W-2:0];
`endif
        return {ovf, v[ACC_W-1] && (mag != '0), mag};
    endfunction

    // NOTE: every always_comb output gets a default before the loop so no latch can be inferred.
    always_comb begin
        res_data = '0;
        res_ovf  = '0;
        for (int i = 0; i < LANES; i++) begin
            sum[i] = acc[i] + to_twos(in_data[i*W +: W]);
            {res_ovf[i], res_data[i*W +: W]} = to_sm(sum[i]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the small per-lane
    // accumulator array is reset too, since a stale partial sum would corrupt the next result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACC;
            term_cnt  <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= '0;
            for (int i = 0; i < LANES; i++) acc[i] <= '0;
        end else if (clear) begin
            state     <= ACC;
            term_cnt  <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= '0;
            for (int i = 0; i < LANES; i++) acc[i] <= '0;
        end else begin
            case (state)
                ACC: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        if (close) begin
                            state     <= OUT;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_data  <= res_data;
                            out_ovf   <= res_ovf;
                            term_cnt  <= '0;
                            for (int i = 0; i < LANES; i++) acc[i] <= '0;
                        end else begin
                            term_cnt <= term_cnt + CNT_W'(1);
                            for (int i = 0; i < LANES; i++) acc[i] <= sum[i];
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state     <= ACC;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule
